split_result_collector: RTL

Collects per-split constraint verdicts (the single-bit `x` outputs of the `split_N` checker modules) for each candidate assignment and reduces them to one verdict per candidate. A candidate satisfies the full constraint set only when every split checker reports `x=1`. The block sits directly downstream of the split checkers. It:
- counts tested and satisfying candidates,
- latches the first satisfying candidate ID,
- buffers satisfying candidate IDs in a small FIFO for the solver back-end.

---
 rtl/split_result_collector.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/split_result_collector.sv
// rtl/split_result_collector.sv - reduces per-split verdicts to candidate verdicts, counts them, queues satisfying IDs
module split_result_collector #(
    parameter int NUM_SPLITS = 4,
    parameter int ID_W       = 16,
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ID_W-1:0]               in_id,
    input  logic [NUM_SPLITS-1:0]         in_x,
    output logic                          sol_valid,
    input  logic                          sol_ready,
    output logic [ID_W-1:0]               sol_id,
    output logic [CNT_W-1:0]              tested_cnt,
    output logic [CNT_W-1:0]              sat_cnt,
    output logic                          found,
    output logic [ID_W-1:0]               first_id,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic            s1_valid_q;
    logic            s1_sat_q;
    logic [ID_W-1:0] s1_id_q;

    logic [CNT_W-1:0] tested_q, tested_d;
    logic [CNT_W-1:0] sat_q, sat_d;
    logic             found_q, found_d;
    logic [ID_W-1:0]  first_id_q, first_id_d;
    logic             overflow_q, overflow_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    logic [ID_W-1:0]  mem_q [FIFO_DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic full;
    logic wr_en;

    // The input never stalls; only a soft clear blocks acceptance.
    assign in_ready = ~clear;
    assign accept   = in_valid & ~clear;

    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign sol_valid  = (fifo_level != '0);
    assign pop        = sol_valid & sol_ready;
    assign full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push       = s1_valid_q & s1_sat_q;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign wr_en      = push & (~full | pop) & ~clear;

    // Head is gated so an empty FIFO shows zero rather than stale storage.
    assign sol_id     = sol_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

    assign tested_cnt = tested_q;
    assign sat_cnt    = sat_q;
    assign found      = found_q;
    assign first_id   = first_id_q;
    assign overflow   = overflow_q;

    // Stage 1: register the accepted candidate and its AND-reduced verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sat_q   <= 1'b0;
            s1_id_q    <= '0;
        end else if (clear) begin
            s1_valid_q <= 1'b0;
            s1_sat_q   <= 1'b0;
            s1_id_q    <= '0;
        end else begin
            s1_valid_q <= accept;
            s1_sat_q   <= &in_x;
            s1_id_q    <= in_id;
        end
    end

    // Stage 2 next state: saturating counters, first-hit latch, FIFO pointers; clear wins.
    always_comb begin
        tested_d   = tested_q;
        sat_d      = sat_q;
        found_d    = found_q;
        first_id_d = first_id_q;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (s1_valid_q) begin
            if (tested_q != '1) begin
                tested_d = tested_q + CNT_W'(1);
            end
            if (s1_sat_q) begin
                if (sat_q != '1) begin
                    sat_d = sat_q + CNT_W'(1);
                end
                if (!found_q) begin
                    found_d    = 1'b1;
                    first_id_d = s1_id_q;
                end
            end
        end
        if (push && full && !pop) begin
            overflow_d = 1'b1;
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (clear) begin
            tested_d   = '0;
            sat_d      = '0;
            found_d    = 1'b0;
            first_id_d = '0;
            overflow_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    // Stage 2 state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tested_q   <= '0;
            sat_q      <= '0;
            found_q    <= 1'b0;
            first_id_q <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            tested_q   <= tested_d;
            sat_q      <= sat_d;
            found_q    <= found_d;
            first_id_q <= first_id_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s1_id_q;
        end
    end

endmodule
